// File: rtl/serial_to_parallel_receiver.sv
// rtl/serial_to_parallel_receiver.sv - MSB-first serial-to-parallel word receiver
// Optional even-parity bit after each word when SERIAL_RX_PARITY_EN is defined.
module serial_to_parallel_receiver #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       abort,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
`ifdef SERIAL_RX_PARITY_EN
  output logic                       parity_err,
`endif
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`ifdef SERIAL_RX_PARITY_EN
  // The full word must be held until the parity bit arrives.
  localparam int SW = WIDTH;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  // The final bit goes straight to data_out, so one fewer stored bit suffices.
  localparam int SW = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state_q, state_d;
  logic [SW-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              perr_q, perr_d;
  logic [WIDTH-1:0]  shift_full;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    shift_full = {shreg_q[WIDTH-2:0], sin};

    if (abort) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (sin_valid) begin
      case (state_q)
        IDLE: begin
          shreg_d = shift_full[SW-1:0];
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_RX_PARITY_EN
            shreg_d = shift_full[SW-1:0];
            cnt_d   = CW'(WIDTH);
            state_d = PARITY;
`else
            data_d  = shift_full;
            valid_d = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            shreg_d = shift_full[SW-1:0];
            cnt_d   = cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          perr_d  = (^shreg_q) ^ sin;
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign bit_cnt    = cnt_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// tb/tb_serial_to_parallel_receiver.sv - directed self-checking bench for serial_to_parallel_receiver
// Appends an even-parity bit to each word when SERIAL_RX_PARITY_EN is defined.
module tb_serial_to_parallel_receiver;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sin = 1'b0;
  logic          sin_valid = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
`ifdef SERIAL_RX_PARITY_EN
  logic          parity_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_to_parallel_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .abort      (abort),
    .data_out   (data_out),
    .data_valid (data_valid),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy),
    .bit_cnt    (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at a falling edge; returns at the next falling edge so outputs are stable.
  task automatic tick(input logic v, input logic b, input logic a);
    sin_valid = v;
    sin       = b;
    abort     = a;
    @(negedge clk);
    sin_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) tick(1'b1, w[i], 1'b0);
`ifdef SERIAL_RX_PARITY_EN
    if (lo == 0) tick(1'b1, ^w, 1'b0);
`endif
  endtask

  task automatic check_done(input string tag, input logic [W-1:0] w);
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    check({tag, "_data"},  32'(data_out),   32'(w));
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_cnt"},   32'(bit_cnt),    32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_cnt",   32'(bit_cnt),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // continuous stream
    tick(1'b1, 1'b1, 1'b0);
    check("aaaa_busy1", 32'(busy),    32'd1);
    check("aaaa_cnt1",  32'(bit_cnt), 32'd1);
    send_bits(16'hAAAA, 14, 0);
    check_done("aaaa", 16'hAAAA);
    tick(1'b0, 1'b0, 1'b0);
    check("aaaa_strobe_width", 32'(data_valid), 32'd0);
    check("aaaa_hold",         32'(data_out),   32'hAAAA);

    // gaps after bits 4 and 11
    for (int i = 0; i < W; i++) begin
      tick(1'b1, 16'hCCCC >> (W - 1 - i), 1'b0);
      if (i == 3 || i == 10) begin
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        check("cccc_gap_cnt",   32'(bit_cnt),    32'(i + 1));
        check("cccc_gap_valid", 32'(data_valid), 32'd0);
        check("cccc_gap_busy",  32'(busy),       32'd1);
      end
    end
`ifdef SERIAL_RX_PARITY_EN
    tick(1'b1, ^16'hCCCC, 1'b0);
`endif
    check_done("cccc", 16'hCCCC);

    // back-to-back frames
    send_bits(16'hF0F0, 15, 0);
    check_done("f0f0", 16'hF0F0);
    tick(1'b1, 1'b1, 1'b0);
    check("b2b_valid_drop", 32'(data_valid), 32'd0);
    check("b2b_cnt1",       32'(bit_cnt),    32'd1);
    check("b2b_hold",       32'(data_out),   32'hF0F0);
    send_bits(16'h8080, 14, 0);
    check_done("8080", 16'h8080);

    // abort mid-frame, with sin_valid on the same edge
    send_bits(16'hE000, 15, 9);
    check("abort_pre_cnt", 32'(bit_cnt), 32'd7);
    tick(1'b1, 1'b0, 1'b1);
    check("abort_cnt",   32'(bit_cnt),    32'd0);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_data",  32'(data_out),   32'h8080);
    tick(1'b0, 1'b0, 1'b1);
    check("abort_idle_cnt", 32'(bit_cnt), 32'd0);
    send_bits(16'hFFE0, 15, 0);
    check_done("ffe0", 16'hFFE0);

    // asynchronous reset mid-frame
    send_bits(16'h1234, 15, 7);
    check("rst_mid_cnt_pre", 32'(bit_cnt), 32'd9);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data",  32'(data_out),   32'd0);
    check("rst_mid_busy",  32'(busy),       32'd0);
    check("rst_mid_cnt",   32'(bit_cnt),    32'd0);
    check("rst_mid_valid", 32'(data_valid), 32'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    send_bits(16'h1234, 15, 0);
    check_done("1234", 16'h1234);

`ifdef SERIAL_RX_PARITY_EN
    for (int i = W - 1; i >= 0; i--) tick(1'b1, 16'h0001 >> i, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("par_ok_valid", 32'(data_valid), 32'd1);
    check("par_ok_data",  32'(data_out),   32'h0001);
    check("par_ok_err",   32'(parity_err), 32'd0);
    for (int i = W - 1; i >= 0; i--) tick(1'b1, 16'h0003 >> i, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("par_bad_valid", 32'(data_valid), 32'd1);
    check("par_bad_data",  32'(data_out),   32'h0003);
    check("par_bad_err",   32'(parity_err), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("par_err_width", 32'(parity_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_receiver.md
# serial_to_parallel_receiver

Receive-side counterpart of the team's parallel-load serial shift register: assembles a WIDTH-bit word from a serial bit stream, MSB first, one bit per qualified clock edge. Presents the completed word on a registered parallel bus with a single-cycle valid strobe. Sits at the far end of the serial link, feeding the word into downstream registers or counters.

## Interface
- WIDTH, 16, word length in bits (≥2)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sin  input  1  serial data bit, MSB of the word first
- sin_valid  input  1  sin is sampled on this edge only when high; gaps allowed
- abort  input  1  synchronous frame discard
- data_out  output  WIDTH  last completed word, held until the next word completes
- data_valid  output  1  one-cycle strobe, data_out newly updated
- busy  output  1  high while a frame is partially received
- bit_cnt  output  $clog2(WIDTH+1)  bits received in current frame

## Operation
- States: IDLE, SHIFT (plus PARITY when the parity option is compiled in).
- IDLE: busy=0, bit_cnt=0. On sin_valid=1: shift sin into the internal register LSB, bit_cnt←1, go to SHIFT.
- SHIFT: on each sin_valid=1, shift reg←{reg[WIDTH-2:0], sin}, bit_cnt+1. sin_valid=0 holds all state (no timeout).
- Completion: the edge sampling bit WIDTH loads data_out←{reg[WIDTH-2:0], sin}, pulses data_valid, returns to IDLE (bit_cnt←0).
- Back-to-back: sin_valid=1 in the cycle data_valid is high is the first bit of the next frame; no dead cycle required.
- abort=1: on that edge shift register, bit_cnt, state → IDLE; data_out unchanged; no data_valid. abort wins over sin_valid on the same edge; the bit is discarded.
- abort in IDLE: no effect.
- Internal shift register is not visible; data_out only changes on completion.

## Timing
- Reset (rst_n=0, any time, asynchronous): state IDLE, data_out=0, data_valid=0, busy=0, bit_cnt=0, shift register 0. Reset mid-frame discards the partial word; first bit after rst_n release starts a fresh frame.
- All outputs registered.
- Latency: data_valid high in the cycle immediately following the edge that samples the last bit (last data bit, or parity bit when enabled).
- data_valid is exactly one cycle wide; never high two consecutive cycles unless two frames complete on consecutive edges (impossible for WIDTH≥2).
- Minimum frame duration: WIDTH edges with sin_valid=1 (WIDTH+1 with parity).
- busy = (state≠IDLE), registered; goes high the cycle after the first bit, low the cycle data_valid rises.

## Configuration
- Macro: SERIAL_RX_PARITY_EN.
- Defined: after the WIDTH data bits, FSM enters PARITY; next sin_valid bit is an even-parity bit (XOR of data bits ^ parity bit must be 0). Adds output parity_err (1 bit) registered alongside data_valid: data_valid pulses and data_out updates regardless; parity_err=1 for that same cycle on mismatch, else 0. parity_err reset value 0. abort during PARITY discards the frame.
- Not defined: no PARITY state, no parity_err port; completion on bit WIDTH as above.

## Test plan
- Reset then stream 16'hAAAA MSB first, sin_valid=1 continuously -> data_valid one cycle after 16th edge, data_out=16'hAAAA, busy low same cycle.
- Stream 16'hCCCC with sin_valid low for 3 cycles after bits 4 and 11 -> bit_cnt frozen during gaps; data_out=16'hCCCC after the 16th valid bit.
- Back-to-back 16'hF0F0 then 16'h8080, no idle cycle -> two data_valid strobes 16 cycles apart, values in order.
- Send 7 bits of 16'hE000, assert abort with sin_valid=1, then send 16'hFFE0 -> no strobe for aborted frame, data_out stays previous value, then 16'hFFE0.
- Drop rst_n for one half-cycle after 9 bits of 16'h1234 -> all outputs 0 immediately; subsequent full 16'h1234 received correctly.
- With SERIAL_RX_PARITY_EN: 16'h0001 + parity 1 -> parity_err=0; 16'h0003 + parity 1 -> data_out=16'h0003, parity_err=1 for one cycle.
